// File: rtl/frame_read_bridge.sv
// Prefetches one frame from SDRAM in bursts into a FIFO that the UDP sender pops word by word.
// Latency: burst request one cycle after the FIFO has room; read_data valid one cycle after read_en.
// Backpressure: bursts are issued only when the FIFO can take the whole burst; pops on an empty FIFO set underflow.
module frame_read_bridge #(
    parameter int unsigned FRAME_WORDS = 307400,
    parameter int unsigned BURST_LEN   = 64,
    parameter int unsigned FIFO_DEPTH  = 512,
    parameter logic [23:0] BASE_ADDR   = 24'h000000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          read_req,
    output logic                          read_req_ack,
    input  logic                          read_en,
    output logic [31:0]                   read_data,
    output logic                          rd_burst_req,
    output logic [23:0]                   rd_burst_addr,
    output logic [9:0]                    rd_burst_len,
    input  logic                          rd_burst_data_valid,
    input  logic [31:0]                   rd_burst_data,
    input  logic                          rd_burst_finish,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          underflow,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_BURST} state_t;

    state_t         state_q, state_d;
    logic [23:0]    addr_q, addr_d;
    logic [31:0]    words_left_q, words_left_d;
    logic           req_q, req_d;
    logic [23:0]    baddr_q, baddr_d;
    logic [9:0]     blen_q, blen_d;
    logic           ack_q, ack_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic           under_q, under_d;
    logic           over_q, over_d;
    logic           pending_q, pending_d;
    // Set once a read_req level has been accepted so a held request starts only one frame.
    logic           taken_q, taken_d;

    logic [31:0]    mem [FIFO_DEPTH];

    logic [31:0]    free_words;
    logic [31:0]    need_words;
    logic [31:0]    len_words;
    logic           full;
    logic           beat_in;
    logic           push;
    logic           pop;
    logic           accept;
    logic           start;

    assign free_words = 32'(FIFO_DEPTH) - 32'(level_q);
    assign need_words = (words_left_q < 32'(BURST_LEN)) ? words_left_q : 32'(BURST_LEN);
    assign len_words  = {22'd0, blen_q};
    assign full       = (level_q == LW'(FIFO_DEPTH));
    // Beats are only accepted for the live burst; a burst being abandoned for a restart is drained and discarded.
    assign beat_in    = (state_q == S_BURST) && !pending_q && rd_burst_data_valid;
    assign push       = beat_in && !full;
    assign pop        = read_en && (level_q != '0);
    assign accept     = read_req && !taken_q;

    // Next-state logic: FIFO bookkeeping, error flags and the IDLE/CHECK/BURST sequencer.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        words_left_d = words_left_q;
        req_d        = req_q;
        baddr_d      = baddr_q;
        blen_d       = blen_q;
        ack_d        = 1'b0;
        rdata_d      = rdata_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        under_d      = under_q;
        over_d       = over_q;
        pending_d    = pending_q;
        taken_d      = read_req ? taken_q : 1'b0;
        start        = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            rdata_d  = mem[rd_ptr_q];
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (beat_in && full) begin
            over_d = 1'b1;
        end
        if (read_en && (level_q == '0)) begin
            under_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    start = 1'b1;
                end
            end
            S_CHECK: begin
                if (accept) begin
                    start = 1'b1;
                end else if (words_left_q == 32'd0) begin
                    state_d = S_IDLE;
                    taken_d = 1'b0;
                end else if (free_words >= need_words) begin
                    req_d   = 1'b1;
                    baddr_d = addr_q;
                    blen_d  = 10'(need_words);
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (accept) begin
                    pending_d = 1'b1;
                    taken_d   = 1'b1;
                end
                if (rd_burst_finish) begin
                    req_d        = 1'b0;
                    addr_d       = addr_q + 24'(blen_q);
                    words_left_d = (words_left_q > len_words) ? (words_left_q - len_words) : 32'd0;
                    state_d      = S_CHECK;
                    if (pending_q || accept) begin
                        start = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Frame (re)start: flush the FIFO and reload the frame cursor; overrides any same-cycle push/pop.
        if (start) begin
            ack_d        = 1'b1;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            level_d      = '0;
            rdata_d      = 32'd0;
            addr_d       = BASE_ADDR;
            words_left_d = 32'(FRAME_WORDS);
            under_d      = 1'b0;
            over_d       = 1'b0;
            pending_d    = 1'b0;
            taken_d      = 1'b1;
            req_d        = 1'b0;
            state_d      = S_CHECK;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= BASE_ADDR;
            words_left_q <= 32'd0;
            req_q        <= 1'b0;
            baddr_q      <= BASE_ADDR;
            blen_q       <= 10'd0;
            ack_q        <= 1'b0;
            rdata_q      <= 32'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            under_q      <= 1'b0;
            over_q       <= 1'b0;
            pending_q    <= 1'b0;
            taken_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            words_left_q <= words_left_d;
            req_q        <= req_d;
            baddr_q      <= baddr_d;
            blen_q       <= blen_d;
            ack_q        <= ack_d;
            rdata_q      <= rdata_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            under_q      <= under_d;
            over_q       <= over_d;
            pending_q    <= pending_d;
            taken_q      <= taken_d;
        end
    end

    // FIFO storage write port; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= rd_burst_data;
        end
    end

    assign read_req_ack  = ack_q;
    assign read_data     = rdata_q;
    assign rd_burst_req  = req_q;
    assign rd_burst_addr = baddr_q;
    assign rd_burst_len  = blen_q;
    assign fifo_level    = level_q;
    assign busy          = (state_q != S_IDLE);
    assign underflow     = under_q;
    assign overflow      = over_q;
endmodule

// File: tb/tb_frame_read_bridge.sv
// Directed bench for frame_read_bridge with a small frame (200 words, 64-word bursts, 128-word FIFO).
// SDRAM model answers one beat per cycle; data word is a fixed function of its address.
module tb_frame_read_bridge;
    logic        clk;
    logic        rst;
    logic        read_req;
    logic        read_req_ack;
    logic        read_en;
    logic [31:0] read_data;
    logic        rd_burst_req;
    logic [23:0] rd_burst_addr;
    logic [9:0]  rd_burst_len;
    logic        rd_burst_data_valid;
    logic [31:0] rd_burst_data;
    logic        rd_burst_finish;
    logic [7:0]  fifo_level;
    logic        busy;
    logic        underflow;
    logic        overflow;

    int checks = 0;
    int failures = 0;

    // SDRAM model state and task-driven stray pulses
    logic        sdram_en;
    logic        m_valid, m_finish, t_valid, t_finish;
    logic [31:0] m_data;
    logic        m_active;
    logic [23:0] m_addr;
    int          m_len, m_cnt;
    logic [23:0] ba[$];
    int          bl[$];

    assign rd_burst_data_valid = m_valid | t_valid;
    assign rd_burst_finish     = m_finish | t_finish;
    assign rd_burst_data       = m_data;

    frame_read_bridge #(
        .FRAME_WORDS(200), .BURST_LEN(64), .FIFO_DEPTH(128), .BASE_ADDR(24'h000000)
    ) dut (
        .clk(clk), .rst(rst), .read_req(read_req), .read_req_ack(read_req_ack),
        .read_en(read_en), .read_data(read_data), .rd_burst_req(rd_burst_req),
        .rd_burst_addr(rd_burst_addr), .rd_burst_len(rd_burst_len),
        .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_data(rd_burst_data),
        .rd_burst_finish(rd_burst_finish), .fifo_level(fifo_level), .busy(busy),
        .underflow(underflow), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [23:0] a);
        return {a[7:0] ^ 8'h5A, a[15:8], a[7:0], 8'h00};
    endfunction

    // SDRAM responder: latch a request, stream len beats, then a one-cycle finish
    always @(posedge clk) begin
        #1;
        if (!sdram_en) begin
            m_valid = 1'b0; m_finish = 1'b0; m_active = 1'b0;
        end else if (!m_active) begin
            m_valid = 1'b0; m_finish = 1'b0;
            if (rd_burst_req) begin
                m_active = 1'b1; m_addr = rd_burst_addr; m_len = int'(rd_burst_len); m_cnt = 0;
                ba.push_back(rd_burst_addr); bl.push_back(int'(rd_burst_len));
            end
        end else if (m_cnt < m_len) begin
            m_valid = 1'b1; m_data = word_at(m_addr + 24'(m_cnt)); m_cnt++;
        end else begin
            m_valid = 1'b0; m_finish = 1'b1; m_active = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1; sdram_en = 1'b0; tick(); rst = 1'b0;
        ba.delete(); bl.delete(); tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; #3;
        checks++; if (read_req_ack !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0", read_req_ack); end
        checks++; if (rd_burst_req !== 1'b0) begin failures++; $display("FAIL rst_breq got=%b exp=0", rd_burst_req); end
        checks++; if (rd_burst_addr !== 24'h0) begin failures++; $display("FAIL rst_baddr got=%h exp=0", rd_burst_addr); end
        checks++; if (rd_burst_len !== 10'd0) begin failures++; $display("FAIL rst_blen got=%0d exp=0", rd_burst_len); end
        checks++; if (read_data !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", read_data); end
        checks++; if (fifo_level !== 8'd0) begin failures++; $display("FAIL rst_level got=%0d exp=0", fifo_level); end
        checks++; if ({busy, underflow, overflow} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {busy, underflow, overflow}); end
        tick(); tick(); rst = 1'b0;
        repeat (6) tick();
        checks++; if (rd_burst_req !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL no_req_idle breq=%b busy=%b exp=0/0", rd_burst_req, busy); end
    endtask

    task automatic test_frame_fill();
        int acks = 0;
        sdram_en = 1'b1; read_req = 1'b1;
        repeat (300) begin tick(); if (read_req_ack) acks++; end
        checks++; if (acks !== 1) begin failures++; $display("FAIL fill_acks got=%0d exp=1", acks); end
        checks++; if (ba.size() !== 2) begin failures++; $display("FAIL fill_bursts got=%0d exp=2", ba.size()); end
        else begin
            checks++; if (ba[0] !== 24'd0 || bl[0] !== 64) begin failures++; $display("FAIL fill_b0 got=%0d/%0d exp=0/64", ba[0], bl[0]); end
            checks++; if (ba[1] !== 24'd64 || bl[1] !== 64) begin failures++; $display("FAIL fill_b1 got=%0d/%0d exp=64/64", ba[1], bl[1]); end
        end
        checks++; if (fifo_level !== 8'd128) begin failures++; $display("FAIL fill_level got=%0d exp=128", fifo_level); end
        checks++; if (busy !== 1'b1 || rd_burst_req !== 1'b0) begin failures++; $display("FAIL fill_stall busy=%b breq=%b exp=1/0", busy, rd_burst_req); end
        read_req = 1'b0;
    endtask

    task automatic test_pop_latency();
        sdram_en = 1'b0; tick();
        read_en = 1'b1; repeat (123) tick(); read_en = 1'b0; tick();
        checks++; if (fifo_level !== 8'd5) begin failures++; $display("FAIL lat_level5 got=%0d exp=5", fifo_level); end
        checks++; if (read_data !== word_at(24'd122)) begin failures++; $display("FAIL lat_prev got=%h exp=%h", read_data, word_at(24'd122)); end
        read_en = 1'b1; tick(); read_en = 1'b0;
        checks++; if (read_data !== word_at(24'd123)) begin failures++; $display("FAIL lat_1cyc got=%h exp=%h", read_data, word_at(24'd123)); end
        checks++; if (fifo_level !== 8'd4) begin failures++; $display("FAIL lat_level4 got=%0d exp=4", fifo_level); end
        tick();
        checks++; if (read_data !== word_at(24'd123)) begin failures++; $display("FAIL lat_2cyc got=%h exp=%h", read_data, word_at(24'd123)); end
    endtask

    task automatic test_underflow();
        read_en = 1'b1; repeat (4) tick(); read_en = 1'b0; tick();
        checks++; if (fifo_level !== 8'd0 || underflow !== 1'b0) begin failures++; $display("FAIL uf_pre level=%0d uf=%b exp=0/0", fifo_level, underflow); end
        read_en = 1'b1; tick(); read_en = 1'b0;
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL uf_set got=%b exp=1", underflow); end
        checks++; if (read_data !== word_at(24'd127) || fifo_level !== 8'd0) begin failures++; $display("FAIL uf_hold data=%h level=%0d exp=%h/0", read_data, fifo_level, word_at(24'd127)); end
        checks++; if (rd_burst_req !== 1'b1 || rd_burst_addr !== 24'd128 || rd_burst_len !== 10'd64) begin failures++; $display("FAIL uf_burst req=%b addr=%0d len=%0d exp=1/128/64", rd_burst_req, rd_burst_addr, rd_burst_len); end
        read_req = 1'b1; tick(); read_req = 1'b0; tick();
        checks++; if (read_req_ack !== 1'b0) begin failures++; $display("FAIL uf_no_ack_in_burst got=%b exp=0", read_req_ack); end
        t_finish = 1'b1; tick(); t_finish = 1'b0;
        checks++; if (read_req_ack !== 1'b1 || underflow !== 1'b0) begin failures++; $display("FAIL uf_clear ack=%b uf=%b exp=1/0", read_req_ack, underflow); end
        checks++; if (read_data !== 32'h0) begin failures++; $display("FAIL uf_flush_data got=%h exp=0", read_data); end
    endtask

    task automatic test_restart_in_burst();
        int n;
        bit got;
        pulse_reset(); sdram_en = 1'b1;
        read_req = 1'b1; tick(); read_req = 1'b0;
        n = 0; while (ba.size() < 2 && n < 300) begin tick(); n++; end
        repeat (10) tick();
        checks++; if (rd_burst_req !== 1'b1 || rd_burst_addr !== 24'd64) begin failures++; $display("FAIL rs_mid req=%b addr=%0d exp=1/64", rd_burst_req, rd_burst_addr); end
        read_req = 1'b1; tick(); read_req = 1'b0;
        got = 1'b0; n = 0;
        while (!got && n < 200) begin tick(); n++; if (read_req_ack) got = 1'b1; end
        checks++; if (!got) begin failures++; $display("FAIL rs_ack got=timeout exp=ack"); end
        checks++; if (fifo_level !== 8'd0) begin failures++; $display("FAIL rs_level got=%0d exp=0", fifo_level); end
        checks++; if (rd_burst_req !== 1'b0) begin failures++; $display("FAIL rs_req_dropped got=%b exp=0", rd_burst_req); end
        tick();
        checks++; if (read_req_ack !== 1'b0) begin failures++; $display("FAIL rs_ack_width got=%b exp=0", read_req_ack); end
        n = 0; while (ba.size() < 3 && n < 50) begin tick(); n++; end
        checks++; if (ba.size() < 3) begin failures++; $display("FAIL rs_next got=%0d bursts exp=3", ba.size()); end
        else if (ba[2] !== 24'd0 || bl[2] !== 64) begin failures++; $display("FAIL rs_next got=%0d/%0d exp=0/64", ba[2], bl[2]); end
    endtask

    task automatic test_drain();
        int popped = 0, errs = 0;
        bit pend = 1'b0, done = 1'b0;
        logic [23:0] exp_a[4] = '{24'd0, 24'd64, 24'd128, 24'd192};
        int exp_l[4] = '{64, 64, 64, 8};
        pulse_reset(); sdram_en = 1'b1;
        read_req = 1'b1; tick(); read_req = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            tick();
            if (pend) begin
                if (read_data !== word_at(24'(popped))) errs++;
                popped++;
            end
            pend = 1'b0; read_en = 1'b0;
            if ((i % 3) == 0 && fifo_level != 8'd0) begin read_en = 1'b1; pend = 1'b1; end
            if (popped == 200 && !busy && !pend) done = 1'b1;
        end
        read_en = 1'b0;
        checks++; if (!done) begin failures++; $display("FAIL drain_done popped=%0d busy=%b exp=200/0", popped, busy); end
        checks++; if (errs !== 0) begin failures++; $display("FAIL drain_order bad_words=%0d exp=0", errs); end
        checks++; if (ba.size() !== 4) begin failures++; $display("FAIL drain_bursts got=%0d exp=4", ba.size()); end
        else begin
            for (int k = 0; k < 4; k++) begin
                checks++; if (ba[k] !== exp_a[k] || bl[k] !== exp_l[k]) begin failures++; $display("FAIL drain_b%0d got=%0d/%0d exp=%0d/%0d", k, ba[k], bl[k], exp_a[k], exp_l[k]); end
            end
        end
        checks++; if (underflow !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL drain_flags uf=%b of=%b exp=0/0", underflow, overflow); end
    endtask

    task automatic test_async_reset();
        int n;
        pulse_reset(); sdram_en = 1'b1;
        read_req = 1'b1; tick(); read_req = 1'b0;
        n = 0; while (fifo_level < 8'd10 && n < 100) begin tick(); n++; end
        read_en = 1'b1; tick(); read_en = 1'b0;
        #3; rst = 1'b1; sdram_en = 1'b0; #1;
        checks++; if (rd_burst_req !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL ar_req_busy req=%b busy=%b exp=0/0", rd_burst_req, busy); end
        checks++; if (rd_burst_len !== 10'd0 || rd_burst_addr !== 24'd0) begin failures++; $display("FAIL ar_burst len=%0d addr=%0d exp=0/0", rd_burst_len, rd_burst_addr); end
        checks++; if (fifo_level !== 8'd0 || read_data !== 32'h0) begin failures++; $display("FAIL ar_fifo level=%0d data=%h exp=0/0", fifo_level, read_data); end
        tick(); rst = 1'b0;
        t_valid = 1'b1; t_finish = 1'b1; tick(); tick(); t_valid = 1'b0; t_finish = 1'b0; tick();
        checks++; if (busy !== 1'b0 || fifo_level !== 8'd0 || rd_burst_req !== 1'b0) begin failures++; $display("FAIL ar_stray busy=%b level=%0d req=%b exp=0/0/0", busy, fifo_level, rd_burst_req); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL ar_flags of=%b uf=%b exp=0/0", overflow, underflow); end
    endtask

    initial begin
        rst = 1'b1; read_req = 1'b0; read_en = 1'b0; sdram_en = 1'b0;
        t_valid = 1'b0; t_finish = 1'b0;
        m_valid = 1'b0; m_finish = 1'b0; m_data = 32'h0; m_active = 1'b0;
        m_addr = 24'h0; m_len = 0; m_cnt = 0;
        test_reset();
        test_frame_fill();
        test_pop_latency();
        test_underflow();
        test_restart_in_burst();
        test_drain();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
